vehicle_detect_cond: RTL and testbench
======================================

VEHICLE_DETECT_COND -- requirements
Module: vehicle_detect_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized sensor level must differ from the debounced level before the debounced level changes; legal range 1..15.
REQ-002 Parameter WAIT_MAX, default 200: wait-count threshold for the starvation flag; legal range 1..255.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 i_clk  input  1  rising-edge clock, shared with the NS/EW/yellow counters and the traffic core.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_NS_sensor  input  1  raw, asynchronous NS loop sensor (1 = vehicle present).
REQ-007 i_EW_sensor  input  1  raw, asynchronous EW loop sensor.
REQ-008 i_NS_green  input  1  NS_green fed back from the traffic core.
REQ-009 i_EW_green  input  1  EW_green fed back from the traffic core.
REQ-010 o_NS_vehicle_detect  output  1  conditioned NS request; drives the core's NS_vehicle_detect.
REQ-011 o_EW_vehicle_detect  output  1  conditioned EW request; drives the core's EW_vehicle_detect.
REQ-012 o_NS_wait  output  8  cycles the NS request has waited without green.
REQ-013 o_EW_wait  output  8  cycles the EW request has waited without green.
REQ-014 o_NS_starved  output  1  1 when o_NS_wait >= WAIT_MAX.
REQ-015 o_EW_starved  output  1  1 when o_EW_wait >= WAIT_MAX.

Function (identical, independent per lane; X = NS or EW)
REQ-016 Each i_X_sensor SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-017 The debounce counter SHALL increment each cycle the synchronized level differs from the debounced level, and SHALL clear on any cycle the levels match.
REQ-018 When the counter reaches DEBOUNCE_CYCLES, the debounced level SHALL take the synchronized value and the counter SHALL clear in the same edge.
REQ-019 A clean sensor edge SHALL therefore reach the debounced level exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples the new level.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the debounced level.
REQ-021 A request latch SHALL set on the edge after a debounced 0->1 transition.
REQ-022 The request latch SHALL clear on any edge where i_X_green = 1.
REQ-023 If set and clear occur in the same cycle, clear SHALL win, because the arriving vehicle is being served.
REQ-024 o_X_vehicle_detect SHALL be a register equal to (latch OR debounced level), so a vehicle that leaves before service keeps its request until its green.
REQ-025 o_X_wait SHALL increment by 1 each cycle where o_X_vehicle_detect = 1 and i_X_green = 0.
REQ-026 o_X_wait SHALL saturate at 255 with no wrap, SHALL clear to 0 on any cycle with i_X_green = 1, and SHALL hold otherwise.
REQ-027 o_X_starved SHALL be registered and SHALL follow o_X_wait with one cycle of latency.
REQ-028 If i_NS_green and i_EW_green are both 1, each lane SHALL still clear independently; no error is flagged.

Reset
REQ-029 Asserting i_rst SHALL immediately clear all state: synchronizer flops, debounced levels, debounce counters, latches, wait counters, and every output to 0.
REQ-030 Reset asserted mid-debounce or mid-wait SHALL discard all partial progress; after release, a held-high sensor SHALL re-qualify from count 0.
REQ-031 Outputs SHALL be valid on the first rising edge after i_rst deasserts; no minimum reset width beyond one clock is needed.

Verification (DEBOUNCE_CYCLES=4, WAIT_MAX=20)
REQ-032 i_NS_sensor 0->1 and held, greens 0 -> o_NS_vehicle_detect=1 exactly 7 edges after the first sampling edge; o_NS_wait then counts 1,2,3...
REQ-033 i_EW_sensor 3-cycle high pulse -> o_EW_vehicle_detect stays 0 and o_EW_wait stays 0.
REQ-034 NS sensor qualified then dropped, green withheld 30 cycles -> o_NS_vehicle_detect stays 1, o_NS_wait reaches 20, and o_NS_starved=1 one cycle later.
REQ-035 i_NS_green=1 for one cycle with a pending NS request and sensor low -> o_NS_vehicle_detect=0, o_NS_wait=0, o_NS_starved=0 on the following cycles.
REQ-036 Request held 300 cycles without green -> o_X_wait saturates at 255 and stays there.
REQ-037 i_rst pulsed mid-wait (o_NS_wait=12) -> all outputs 0 at once; with the sensor held high after release, detect returns 7 edges later and wait restarts at 1.

Source files
------------

// File: rtl/vehicle_detect_cond.sv
// Vehicle-detect conditioning: per-lane sync, debounce, request latch, wait counter and starvation flag.
// Two independent lanes (NS, EW); detect is registered, wait saturates at 255, starved lags wait by one cycle.
module vehicle_detect_lane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WAIT_MAX        = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor,
  input  logic       green,
  output logic       detect,
  output logic [7:0] wait_cnt,
  output logic       starved
);
  localparam logic [3:0] DB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] WAIT_THR = 8'(WAIT_MAX);

  logic       sync1, sync2;
  logic       deb, deb_d;
  logic [3:0] db_cnt;
  logic       req_latch;
  logic       latch_nxt;

  // Green clears the latch in the same cycle a rise would set it: the vehicle is being served.
  always_comb begin
    latch_nxt = req_latch;
    if (green)
      latch_nxt = 1'b0;
    else if (deb && !deb_d)
      latch_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb       <= 1'b0;
      deb_d     <= 1'b0;
      db_cnt    <= 4'd0;
      req_latch <= 1'b0;
      detect    <= 1'b0;
      wait_cnt  <= 8'd0;
      starved   <= 1'b0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      deb_d <= deb;
      if (sync2 == deb) begin
        db_cnt <= 4'd0;
      end else if (db_cnt == DB_LAST) begin
        deb    <= sync2;
        db_cnt <= 4'd0;
      end else begin
        db_cnt <= db_cnt + 4'd1;
      end
      req_latch <= latch_nxt;
      // Using the post-clear latch keeps detect from lingering a cycle past green.
      detect    <= latch_nxt | deb;
      if (green)
        wait_cnt <= 8'd0;
      else if (detect && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
      starved <= (wait_cnt >= WAIT_THR);
    end
  end
endmodule

module vehicle_detect_cond #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WAIT_MAX        = 200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_NS_sensor,
  input  logic       i_EW_sensor,
  input  logic       i_NS_green,
  input  logic       i_EW_green,
  output logic       o_NS_vehicle_detect,
  output logic       o_EW_vehicle_detect,
  output logic [7:0] o_NS_wait,
  output logic [7:0] o_EW_wait,
  output logic       o_NS_starved,
  output logic       o_EW_starved
);
  vehicle_detect_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WAIT_MAX(WAIT_MAX)) u_ns (
    .clk      (i_clk),
    .rst      (i_rst),
    .sensor   (i_NS_sensor),
    .green    (i_NS_green),
    .detect   (o_NS_vehicle_detect),
    .wait_cnt (o_NS_wait),
    .starved  (o_NS_starved)
  );

  vehicle_detect_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WAIT_MAX(WAIT_MAX)) u_ew (
    .clk      (i_clk),
    .rst      (i_rst),
    .sensor   (i_EW_sensor),
    .green    (i_EW_green),
    .detect   (o_EW_vehicle_detect),
    .wait_cnt (o_EW_wait),
    .starved  (o_EW_starved)
  );
endmodule

// File: tb/tb_vehicle_detect_cond.sv
// Directed bench for vehicle_detect_cond with DEBOUNCE_CYCLES=4, WAIT_MAX=20.
module tb_vehicle_detect_cond;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ns_sensor = 1'b0, ew_sensor = 1'b0;
  logic       ns_green = 1'b0, ew_green = 1'b0;
  logic       ns_det, ew_det, ns_starved, ew_starved;
  logic [7:0] ns_wait, ew_wait;
  int         vec = 0;
  int         errs = 0;

  vehicle_detect_cond #(.DEBOUNCE_CYCLES(4), .WAIT_MAX(20)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_NS_sensor         (ns_sensor),
    .i_EW_sensor         (ew_sensor),
    .i_NS_green          (ns_green),
    .i_EW_green          (ew_green),
    .o_NS_vehicle_detect (ns_det),
    .o_EW_vehicle_detect (ew_det),
    .o_NS_wait           (ns_wait),
    .o_EW_wait           (ew_wait),
    .o_NS_starved        (ns_starved),
    .o_EW_starved        (ew_starved)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_dut;
    ns_sensor = 1'b0; ew_sensor = 1'b0; ns_green = 1'b0; ew_green = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    ns_sensor = 1'b1; ew_sensor = 1'b1;
    rst = 1'b1;
    tick(); tick();
    if ({ns_det, ew_det, ns_wait, ew_wait, ns_starved, ew_starved} !== 20'd0) begin
      $display("FAIL reset_outputs got=%h want=0", {ns_det, ew_det, ns_wait, ew_wait, ns_starved, ew_starved});
      errs++;
    end
    vec++;
  endtask

  task automatic test_qualify;
    rst_dut();
    ns_sensor = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (ns_det !== 1'b0) begin
        $display("FAIL qualify_early edge=%0d got=%b want=0", i, ns_det); errs++;
      end
      vec++;
    end
    tick();
    if (ns_det !== 1'b1) begin
      $display("FAIL qualify_edge7 got=%b want=1", ns_det); errs++;
    end
    vec++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (ns_wait !== 8'(k)) begin
        $display("FAIL qualify_wait got=%0d want=%0d", ns_wait, k); errs++;
      end
      vec++;
    end
    if (ew_det !== 1'b0 || ew_wait !== 8'd0) begin
      $display("FAIL qualify_ew_idle got=%b/%0d want=0/0", ew_det, ew_wait); errs++;
    end
    vec++;
  endtask

  task automatic test_glitch;
    rst_dut();
    ew_sensor = 1'b1;
    repeat (3) tick();
    ew_sensor = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ew_det !== 1'b0 || ew_wait !== 8'd0) begin
        $display("FAIL glitch_ignored cyc=%0d got=%b/%0d want=0/0", i, ew_det, ew_wait); errs++;
      end
      vec++;
    end
  endtask

  // Request latched, sensor dropped, green withheld; then one green cycle clears everything.
  task automatic test_starve_and_clear;
    rst_dut();
    ns_sensor = 1'b1;
    repeat (7) tick();
    ns_sensor = 1'b0;
    repeat (19) tick();
    if (ns_wait !== 8'd19 || ns_starved !== 1'b0) begin
      $display("FAIL starve_e26 got=%0d/%b want=19/0", ns_wait, ns_starved); errs++;
    end
    vec++;
    tick();
    if (ns_wait !== 8'd20 || ns_starved !== 1'b0) begin
      $display("FAIL starve_e27 got=%0d/%b want=20/0", ns_wait, ns_starved); errs++;
    end
    vec++;
    tick();
    if (ns_starved !== 1'b1) begin
      $display("FAIL starve_flag got=%b want=1", ns_starved); errs++;
    end
    vec++;
    repeat (9) tick();
    if (ns_det !== 1'b1 || ns_wait !== 8'd30) begin
      $display("FAIL starve_hold got=%b/%0d want=1/30", ns_det, ns_wait); errs++;
    end
    vec++;
    ns_green = 1'b1;
    tick();
    ns_green = 1'b0;
    if (ns_det !== 1'b0 || ns_wait !== 8'd0) begin
      $display("FAIL green_clear got=%b/%0d want=0/0", ns_det, ns_wait); errs++;
    end
    vec++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ns_det !== 1'b0 || ns_wait !== 8'd0 || ns_starved !== 1'b0) begin
        $display("FAIL green_after cyc=%0d got=%b/%0d/%b want=0/0/0", i, ns_det, ns_wait, ns_starved); errs++;
      end
      vec++;
    end
  endtask

  task automatic test_saturate;
    rst_dut();
    ew_sensor = 1'b1;
    repeat (261) tick();
    if (ew_wait !== 8'd254) begin
      $display("FAIL sat_pre got=%0d want=254", ew_wait); errs++;
    end
    vec++;
    repeat (39) tick();
    if (ew_wait !== 8'd255 || ew_starved !== 1'b1) begin
      $display("FAIL sat_value got=%0d/%b want=255/1", ew_wait, ew_starved); errs++;
    end
    vec++;
    tick();
    if (ew_wait !== 8'd255) begin
      $display("FAIL sat_hold got=%0d want=255", ew_wait); errs++;
    end
    vec++;
    if (ns_wait !== 8'd0 || ns_det !== 1'b0) begin
      $display("FAIL sat_ns_idle got=%b/%0d want=0/0", ns_det, ns_wait); errs++;
    end
    vec++;
  endtask

  task automatic test_both_green;
    rst_dut();
    ns_sensor = 1'b1; ew_sensor = 1'b1;
    repeat (12) tick();
    if (ns_wait !== 8'd5 || ew_wait !== 8'd5) begin
      $display("FAIL both_pre got=%0d/%0d want=5/5", ns_wait, ew_wait); errs++;
    end
    vec++;
    ns_green = 1'b1; ew_green = 1'b1;
    tick();
    if (ns_wait !== 8'd0 || ew_wait !== 8'd0) begin
      $display("FAIL both_green got=%0d/%0d want=0/0", ns_wait, ew_wait); errs++;
    end
    vec++;
    ns_green = 1'b0;
    tick();
    if (ns_wait !== 8'd1 || ew_wait !== 8'd0) begin
      $display("FAIL both_independent got=%0d/%0d want=1/0", ns_wait, ew_wait); errs++;
    end
    vec++;
    ew_green = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    rst_dut();
    ns_sensor = 1'b1;
    repeat (19) tick();
    if (ns_wait !== 8'd12) begin
      $display("FAIL midrst_pre got=%0d want=12", ns_wait); errs++;
    end
    vec++;
    #2 rst = 1'b1;
    #1;
    if ({ns_det, ew_det, ns_wait, ew_wait, ns_starved, ew_starved} !== 20'd0) begin
      $display("FAIL midrst_async got=%h want=0", {ns_det, ew_det, ns_wait, ew_wait, ns_starved, ew_starved});
      errs++;
    end
    vec++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (ns_det !== 1'b0) begin
        $display("FAIL midrst_requal edge=%0d got=%b want=0", i, ns_det); errs++;
      end
      vec++;
    end
    tick();
    if (ns_det !== 1'b1 || ns_wait !== 8'd0) begin
      $display("FAIL midrst_detect got=%b/%0d want=1/0", ns_det, ns_wait); errs++;
    end
    vec++;
    tick();
    if (ns_wait !== 8'd1) begin
      $display("FAIL midrst_wait got=%0d want=1", ns_wait); errs++;
    end
    vec++;
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_glitch();
    test_starve_and_clear();
    test_saturate();
    test_both_green();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
